// File: rtl/rrc_symbol_scheduler.sv
// -----------------------------------------------------------------------------
// rrc_symbol_scheduler
//
// Converts a symbol-rate valid/ready stream into the sample-rate input of the
// fir_rrc pulse-shaping filter. Each accepted symbol is followed by SPS-1
// zeros. The block also owns the filter's synchronous reset: it holds the
// filter in reset while idle and priming, and on shutdown it drives
// FLUSH_LEN zeros to clear the delay line. Missing symbols are replaced by
// zeros and counted, so the sample cadence never slips.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   enable         level: high = stream, low = orderly stop at symbol boundary
//   sym_in         signed symbol value
//   sym_valid      sym_in valid
//   sym_ready      scheduler takes sym_in this cycle
//   filt_in        registered sample to the filter
//   filt_rst       active-high synchronous reset to the filter
//   sym_phase      filt_in carries a symbol slot this cycle
//   busy           state is not IDLE
//   underrun_count saturating count of missed symbol slots
//   state_dbg      current FSM state (IDLE=0, PRIME=1, RUN=2, FLUSH=3)
//
// Handshake: a symbol transfers on a rising edge where sym_valid and
// sym_ready are both high. sym_ready depends only on registered state and
// enable, never on sym_valid; sym_valid outside a ready cycle is ignored and
// a held valid is taken at most once per symbol period.
// -----------------------------------------------------------------------------
module rrc_symbol_scheduler #(
    parameter int WIDTH     = 12,
    parameter int SPS       = 4,
    parameter int FLUSH_LEN = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] sym_in,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    output logic signed [WIDTH-1:0] filt_in,
    output logic                    filt_rst,
    output logic                    sym_phase,
    output logic                    busy,
    output logic [15:0]             underrun_count,
    output logic [1:0]              state_dbg
);

    localparam int PHASE_W = (SPS > 1) ? $clog2(SPS) : 1;
    // Counter serves both the 2-cycle prime and the flush length.
    localparam int CNT_W   = $clog2(FLUSH_LEN + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   gen_cnt;
    logic [15:0]        underrun_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (enable) state_next = PRIME;
            PRIME: if (gen_cnt == CNT_W'(1)) state_next = RUN;
            // Stop only at a symbol boundary so the current period completes.
            RUN:   if ((phase == '0) && !enable) state_next = FLUSH;
            FLUSH: if (gen_cnt == CNT_W'(FLUSH_LEN - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic (from registered state, plus enable for the ready term)
    always_comb begin
        sym_ready = 1'b0;
        filt_rst  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                filt_rst = 1'b1;
                busy     = 1'b0;
            end
            PRIME: filt_rst = 1'b1;
            RUN:   sym_ready = (phase == '0) && enable;
            FLUSH: ;
            default: begin
                filt_rst = 1'b1;
                busy     = 1'b0;
            end
        endcase
    end

    assign state_dbg      = state;
    assign underrun_count = underrun_q;

    // Phase and general counters; both restart on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            gen_cnt <= '0;
        end else begin
            if ((state == RUN) && (state_next == RUN)) begin
                phase <= (phase == PHASE_W'(SPS - 1)) ? '0 : phase + PHASE_W'(1);
            end else begin
                phase <= '0;
            end

            if (state_next != state) begin
                gen_cnt <= '0;
            end else if ((state == PRIME) || (state == FLUSH)) begin
                gen_cnt <= gen_cnt + CNT_W'(1);
            end else begin
                gen_cnt <= '0;
            end
        end
    end

    // Sample datapath. Every slot that is not an accepted symbol is zero,
    // including underrun slots, non-zero phases, and the flush sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_in    <= '0;
            sym_phase  <= 1'b0;
            underrun_q <= '0;
        end else begin
            filt_in   <= (sym_ready && sym_valid) ? sym_in : '0;
            sym_phase <= sym_ready;
            if (sym_ready && !sym_valid && (underrun_q != 16'hFFFF)) begin
                underrun_q <= underrun_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rrc_symbol_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rrc_symbol_scheduler
//
// Directed bench for rrc_symbol_scheduler with WIDTH=12, SPS=4, FLUSH_LEN=21.
// A table of per-cycle records (inputs plus hand-computed outputs) covers
// start-up, cadence, underrun, held valid and stop/flush with restart.
// Reset-under-stimulus and asynchronous reset mid-RUN are written by hand.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_rrc_symbol_scheduler;

    localparam int WIDTH     = 12;
    localparam int SPS       = 4;
    localparam int FLUSH_LEN = 21;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             enable;
    logic [WIDTH-1:0] sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic [WIDTH-1:0] filt_in;
    logic             filt_rst;
    logic             sym_phase;
    logic             busy;
    logic [15:0]      underrun_count;
    logic [1:0]       state_dbg;

    rrc_symbol_scheduler #(
        .WIDTH    (WIDTH),
        .SPS      (SPS),
        .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sym_in        (sym_in),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .filt_in       (filt_in),
        .filt_rst      (filt_rst),
        .sym_phase     (sym_phase),
        .busy          (busy),
        .underrun_count(underrun_count),
        .state_dbg     (state_dbg)
    );

    // Scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Vector table
    typedef struct {
        logic             en;
        logic             vld;
        logic [WIDTH-1:0] sym;
        logic             rdy;
        logic [WIDTH-1:0] fin;
        logic             rst;
        logic             sph;
        logic             bsy;
        logic [15:0]      und;
    } vec_t;

    vec_t vecs[$];

    task automatic vec(input logic en, input logic vld, input int sym,
                       input logic rdy, input int fin, input logic rst,
                       input logic sph, input logic bsy, input int und);
        vec_t v;
        v.en  = en;
        v.vld = vld;
        v.sym = WIDTH'(sym);
        v.rdy = rdy;
        v.fin = WIDTH'(fin);
        v.rst = rst;
        v.sph = sph;
        v.bsy = bsy;
        v.und = 16'(und);
        vecs.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".filt_rst"}, 32'(filt_rst), 32'(1));
        chk({tag, ".filt_in"}, 32'(filt_in), 32'(0));
        chk({tag, ".sym_ready"}, 32'(sym_ready), 32'(0));
        chk({tag, ".sym_phase"}, 32'(sym_phase), 32'(0));
        chk({tag, ".busy"}, 32'(busy), 32'(0));
        chk({tag, ".underrun"}, 32'(underrun_count), 32'(0));
        chk({tag, ".state"}, 32'(state_dbg), 32'(0));
    endtask

    task automatic build_table();
        //  en vld sym      rdy fin    rst sph bsy und
        // Start-up: enable sampled at end of row 1, PRIME rows 2-3, RUN from row 4.
        vec(0, 0, 0,       0, 0,     1, 0, 0, 0);
        vec(1, 0, 0,       0, 0,     1, 0, 0, 0);
        vec(1, 0, 0,       0, 0,     1, 0, 1, 0);
        vec(1, 0, 0,       0, 0,     1, 0, 1, 0);
        // Cadence: 100, -200, 2047 always valid.
        vec(1, 1, 100,     1, 0,     0, 0, 1, 0);
        vec(1, 1, -200,    0, 100,   0, 1, 1, 0);
        vec(1, 1, -200,    0, 0,     0, 0, 1, 0);
        vec(1, 1, -200,    0, 0,     0, 0, 1, 0);
        vec(1, 1, -200,    1, 0,     0, 0, 1, 0);
        vec(1, 1, 2047,    0, -200,  0, 1, 1, 0);
        vec(1, 1, 2047,    0, 0,     0, 0, 1, 0);
        vec(1, 1, 2047,    0, 0,     0, 0, 1, 0);
        vec(1, 1, 2047,    1, 0,     0, 0, 1, 0);
        vec(1, 1, 5,       0, 2047,  0, 1, 1, 0);
        vec(1, 1, 5,       0, 0,     0, 0, 1, 0);
        vec(1, 1, 5,       0, 0,     0, 0, 1, 0);
        // Underrun: 5, two empty slots, then 7.
        vec(1, 1, 5,       1, 0,     0, 0, 1, 0);
        vec(1, 0, 0,       0, 5,     0, 1, 1, 0);
        vec(1, 0, 0,       0, 0,     0, 0, 1, 0);
        vec(1, 0, 0,       0, 0,     0, 0, 1, 0);
        vec(1, 0, 0,       1, 0,     0, 0, 1, 0);
        vec(1, 0, 0,       0, 0,     0, 1, 1, 1);
        vec(1, 0, 0,       0, 0,     0, 0, 1, 1);
        vec(1, 0, 0,       0, 0,     0, 0, 1, 1);
        vec(1, 0, 0,       1, 0,     0, 0, 1, 1);
        vec(1, 0, 0,       0, 0,     0, 1, 1, 2);
        vec(1, 0, 0,       0, 0,     0, 0, 1, 2);
        vec(1, 0, 0,       0, 0,     0, 0, 1, 2);
        vec(1, 1, 7,       1, 0,     0, 0, 1, 2);
        // Held valid with constant 300: one transfer per symbol period.
        vec(1, 1, 300,     0, 7,     0, 1, 1, 2);
        vec(1, 1, 300,     0, 0,     0, 0, 1, 2);
        vec(1, 1, 300,     0, 0,     0, 0, 1, 2);
        for (int k = 0; k < 3; k++) begin
            vec(1, 1, 300, 1, 0,     0, 0, 1, 2);
            vec(1, 1, 300, 0, 300,   0, 1, 1, 2);
            vec(1, 1, 300, 0, 0,     0, 0, 1, 2);
            vec(1, 1, 300, 0, 0,     0, 0, 1, 2);
        end
        // Stop: enable drops at phase 2; the period completes, no take at phase 0.
        vec(1, 1, 300,     1, 0,     0, 0, 1, 2);
        vec(1, 1, 300,     0, 300,   0, 1, 1, 2);
        vec(0, 1, 300,     0, 0,     0, 0, 1, 2);
        vec(0, 1, 300,     0, 0,     0, 0, 1, 2);
        vec(0, 1, 300,     0, 0,     0, 0, 1, 2);
        // FLUSH_LEN zero cycles; enable re-raised partway through is ignored.
        for (int i = 0; i < FLUSH_LEN; i++) begin
            vec((i >= 11) ? 1'b1 : 1'b0, 0, 0, 0, 0, 0, 0, 1, 2);
        end
        // Back in IDLE with enable high: restart through PRIME.
        vec(1, 0, 0,       0, 0,     1, 0, 0, 2);
        vec(1, 0, 0,       0, 0,     1, 0, 1, 2);
        vec(1, 0, 0,       0, 0,     1, 0, 1, 2);
        vec(1, 1, 300,     1, 0,     0, 0, 1, 2);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        sym_valid = 1'b0;
        sym_in    = '0;

        // Reset held while inputs toggle.
        #1;
        check_reset_outputs("reset_t0");
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            enable    = 1'($urandom_range(0, 1));
            sym_valid = 1'($urandom_range(0, 1));
            sym_in    = WIDTH'($urandom_range(0, 4095));
            @(negedge clk);
            check_reset_outputs($sformatf("reset_c%0d", c));
        end
        enable    = 1'b0;
        sym_valid = 1'b0;
        sym_in    = '0;
        rst_n     = 1'b1;

        // Table-driven main sequence.
        build_table();
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            enable    = vecs[i].en;
            sym_valid = vecs[i].vld;
            sym_in    = vecs[i].sym;
            @(negedge clk);
            chk($sformatf("row%0d.sym_ready", i), 32'(sym_ready), 32'(vecs[i].rdy));
            chk($sformatf("row%0d.filt_in", i), 32'(filt_in), 32'(vecs[i].fin));
            chk($sformatf("row%0d.filt_rst", i), 32'(filt_rst), 32'(vecs[i].rst));
            chk($sformatf("row%0d.sym_phase", i), 32'(sym_phase), 32'(vecs[i].sph));
            chk($sformatf("row%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("row%0d.underrun", i), 32'(underrun_count), 32'(vecs[i].und));
            @(posedge clk);
            #1;
        end

        // Async reset at RUN phase 1: outputs clear without a clock edge.
        enable    = 1'b1;
        sym_valid = 1'b0;
        sym_in    = '0;
        #1;
        chk("pre_areset.filt_in", 32'(filt_in), 32'(300));
        chk("pre_areset.sym_phase", 32'(sym_phase), 32'(1));
        chk("pre_areset.state", 32'(state_dbg), 32'(2));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;

        // After release the block stays idle until enable.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            sym_valid = 1'b1;
            sym_in    = WIDTH'(55);
            @(negedge clk);
            check_reset_outputs($sformatf("idle_c%0d", c));
        end
        @(posedge clk);
        #1;
        enable    = 1'b1;
        sym_valid = 1'b1;
        sym_in    = WIDTH'(-1);
        @(negedge clk);
        chk("restart.idle_busy", 32'(busy), 32'(0));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("restart.prime%0d_state", c), 32'(state_dbg), 32'(1));
            chk($sformatf("restart.prime%0d_filt_rst", c), 32'(filt_rst), 32'(1));
            chk($sformatf("restart.prime%0d_ready", c), 32'(sym_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("restart.run_ready", 32'(sym_ready), 32'(1));
        chk("restart.run_filt_rst", 32'(filt_rst), 32'(0));
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        @(negedge clk);
        chk("restart.first_sample", 32'(filt_in), 32'(12'hFFF));
        chk("restart.first_phase", 32'(sym_phase), 32'(1));
        chk("restart.underrun", 32'(underrun_count), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
